// File: rtl/load_store_unit.sv
// Load/store unit: issues word-aligned memory accesses and does byte-lane extraction,
// sign/zero extension and read-modify-write merging itself. Macro LSU_MISALIGNED_EN splits word-crossing accesses.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_in,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [2:0]  mem_data_size,
  input  logic [31:0] mem_out
);

  typedef enum logic [2:0] {
    StIdle, StRdLo, StRdHi, StMerge, StWrLo, StWrHi, StResp
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, fault_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] lo_buf_q, hi_buf_q;

  logic        req_fire, req_fault, crosses;
  logic [31:0] word_a, word_b;
  logic [3:0]  lane_base;
  logic [7:0]  lane_mask;
  logic [63:0] bit_mask, wdata_wide, merged;
  logic [31:0] ld_word, ld_ext;

  // Sizes x00 are bytes, x01 halfwords, everything else a full word.
  function automatic logic is_byte(input logic [2:0] s);
    return s[1:0] == 2'b00;
  endfunction

  function automatic logic is_half(input logic [2:0] s);
    return s[1:0] == 2'b01;
  endfunction

  function automatic logic is_word(input logic [2:0] s);
    return s[1];
  endfunction

  assign req_ready = (state_q == StIdle) && !reset;
  assign req_fire  = req_valid && req_ready;
  assign word_a    = {addr_q[31:2], 2'b00};
  assign word_b    = word_a + 32'd4;

`ifdef LSU_MISALIGNED_EN
  assign req_fault = 1'b0;
  assign crosses   = (is_half(size_q) && addr_q[1:0] == 2'd3) ||
                     (is_word(size_q) && addr_q[1:0] != 2'd0);
`else
  assign req_fault = (is_half(req_size) && req_addr[0]) ||
                     (is_word(req_size) && req_addr[1:0] != 2'd0);
  assign crosses   = 1'b0;
`endif

  // Byte-lane view of the two buffered words, starting at the addressed byte.
  always_comb begin
    lane_base = is_byte(size_q) ? 4'b0001 : (is_half(size_q) ? 4'b0011 : 4'b1111);
    lane_mask = 8'({4'b0000, lane_base} << addr_q[1:0]);
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
    wdata_wide = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    merged     = ({hi_buf_q, lo_buf_q} & ~bit_mask) | (wdata_wide & bit_mask);
    ld_word    = 32'({hi_buf_q, lo_buf_q} >> {addr_q[1:0], 3'b000});
    case (size_q)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {24'b0, ld_word[7:0]};
      3'b101:  ld_ext = {16'b0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          if (req_fault) begin
            state_d = StResp;
          end else if (req_write && is_word(req_size) && req_addr[1:0] == 2'd0) begin
            state_d = StWrLo;
          end else begin
            state_d = StRdLo;
          end
        end
      end
      StRdLo:  state_d = crosses ? StRdHi : StMerge;
`ifdef LSU_MISALIGNED_EN
      StRdHi:  state_d = StMerge;
      StWrHi:  state_d = StResp;
`endif
      StMerge: state_d = write_q ? StWrLo : StResp;
      StWrLo:  state_d = crosses ? StWrHi : StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      fault_q  <= 1'b0;
      size_q   <= 3'b000;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      lo_buf_q <= 32'b0;
      hi_buf_q <= 32'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        write_q <= req_write;
        fault_q <= req_fault;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Read data lags its strobe by one cycle: word A lands in RD_HI or MERGE.
      if (state_q == StRdHi) begin
        lo_buf_q <= mem_out;
      end
      if (state_q == StMerge) begin
        if (crosses) begin
          hi_buf_q <= mem_out;
        end else begin
          lo_buf_q <= mem_out;
        end
      end
    end
  end

  // An aligned word store has an all-ones mask, so the merge reduces to wdata.
  always_comb begin
    mem_read_en     = 1'b0;
    mem_write_en    = 1'b0;
    mem_access_addr = 32'b0;
    mem_in          = 32'b0;
    mem_data_size   = 3'b010;
    resp_valid      = 1'b0;
    resp_rdata      = 32'b0;
    resp_misaligned = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StRdLo: begin
          mem_read_en     = 1'b1;
          mem_access_addr = word_a;
        end
        StRdHi: begin
          mem_read_en     = 1'b1;
          mem_access_addr = word_b;
        end
        StWrLo: begin
          mem_write_en    = 1'b1;
          mem_access_addr = word_a;
          mem_in          = merged[31:0];
        end
        StWrHi: begin
          mem_write_en    = 1'b1;
          mem_access_addr = word_b;
          mem_in          = merged[63:32];
        end
        StResp: begin
          resp_valid      = 1'b1;
          resp_misaligned = fault_q;
          resp_rdata      = (write_q || fault_q) ? 32'b0 : ld_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a response scoreboard plus reset sequences.
// Works with and without LSU_MISALIGNED_EN.
module tb_load_store_unit;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [31:0] mem_access_addr, mem_in, mem_out;
  logic        mem_write_en, mem_read_en;
  logic [2:0]  mem_data_size;

  load_store_unit dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_access_addr (mem_access_addr),
    .mem_in          (mem_in),
    .mem_write_en    (mem_write_en),
    .mem_read_en     (mem_read_en),
    .mem_data_size   (mem_data_size),
    .mem_out         (mem_out)
  );

`ifdef LSU_MISALIGNED_EN
  localparam bit Split = 1'b1;
`else
  localparam bit Split = 1'b0;
`endif

  // Word memory with 1-cycle read latency; the bench preloads words through the poke port.
  logic [31:0] mem [256];
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_data;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr[9:2]] <= mem_in;
    if (poke_en) mem[poke_idx] <= poke_data;
    if (mem_read_en) mem_out <= mem[mem_access_addr[9:2]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr, wdata, init_a, init_b;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] ia,
                              input logic [31:0] ib, input logic [31:0] rdata, input int lat,
                              input int nrd, input int nwr, input logic [31:0] ea,
                              input logic [31:0] eb);
    vec_t v;
    v = '{wr, size, addr, wdata, ia, ib, rdata, 1'b0, lat, nrd, nwr, ea, eb};
    vecs.push_back(v);
  endfunction

  // Unaligned access: as given when split, otherwise a 1-cycle fault with no strobes.
  function automatic void add_x(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] ia,
                                input logic [31:0] ib, input logic [31:0] rdata, input int lat,
                                input int nrd, input int nwr, input logic [31:0] ea,
                                input logic [31:0] eb);
    vec_t v;
    if (Split) v = '{wr, size, addr, wdata, ia, ib, rdata, 1'b0, lat, nrd, nwr, ea, eb};
    else       v = '{wr, size, addr, wdata, ia, ib, 32'h0, 1'b1, 1, 0, 0, ia, ib};
    vecs.push_back(v);
  endfunction

  task automatic poke(input logic [31:0] waddr, input logic [31:0] d);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_idx  = waddr[9:2];
    poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] wa, wb, first_addr;
    int   cyc, nrd, nwr;
    bit   got, seen;
    exp_t e;
    wa = v.addr & 32'hFFFF_FFFC;
    wb = wa + 32'd4;
    poke(wa, v.init_a);
    poke(wb, v.init_b);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = v.wr;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    e = '{v.exp_rdata, v.exp_mis, v.exp_lat};
    sb_q.push_back(e);
    cyc = 0;
    while (!req_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; nrd = 0; nwr = 0; got = 0; seen = 0; first_addr = 32'h0;
    while (cyc <= 12 && !got) begin
      if (mem_read_en || mem_write_en) begin
        if (!seen) first_addr = mem_access_addr;
        seen = 1;
        if (mem_read_en) nrd++;
        if (mem_write_en) nwr++;
        chk($sformatf("v%0d one strobe", idx), {31'b0, mem_read_en & mem_write_en}, 32'd0);
      end
      if (resp_valid) begin
        got = 1;
        e = sb_q.pop_front();
        chk($sformatf("v%0d rdata", idx), resp_rdata, e.rdata);
        chk($sformatf("v%0d misaligned", idx), {31'b0, resp_misaligned}, {31'b0, e.mis});
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(e.lat));
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) begin
      void'(sb_q.pop_front());
      chk($sformatf("v%0d response timeout", idx), 32'd0, 32'd1);
    end
    if (seen) chk($sformatf("v%0d first addr", idx), first_addr, wa);
    chk($sformatf("v%0d reads", idx), 32'(nrd), 32'(v.exp_rd));
    chk($sformatf("v%0d writes", idx), 32'(nwr), 32'(v.exp_wr));
    @(negedge clk);
    chk($sformatf("v%0d single pulse", idx), {31'b0, resp_valid}, 32'd0);
    chk($sformatf("v%0d ready after", idx), {31'b0, req_ready}, 32'd1);
    chk($sformatf("v%0d word A", idx), mem[wa[9:2]], v.exp_a);
    chk($sformatf("v%0d word B", idx), mem[wb[9:2]], v.exp_b);
  endtask

  task automatic quiet_cycles(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (resp_valid || mem_write_en) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; poke_en = 1'b0; poke_idx = 8'h0; poke_data = 32'h0;

    //   wr size    addr          wdata         init_a        init_b        rdata        lat rd wr exp_a         exp_b
    add  (0, 3'b010, 32'h10,       32'h0,        32'h8899AABB, 32'h0,        32'h8899AABB, 3, 1, 0, 32'h8899AABB, 32'h0);
    add  (0, 3'b000, 32'h13,       32'h0,        32'h80112233, 32'h0,        32'hFFFFFF80, 3, 1, 0, 32'h80112233, 32'h0);
    add  (0, 3'b100, 32'h13,       32'h0,        32'h80112233, 32'h0,        32'h00000080, 3, 1, 0, 32'h80112233, 32'h0);
    add  (0, 3'b001, 32'h12,       32'h0,        32'h80112233, 32'h0,        32'hFFFF8011, 3, 1, 0, 32'h80112233, 32'h0);
    add  (0, 3'b101, 32'h10,       32'h0,        32'h80112233, 32'h0,        32'h00002233, 3, 1, 0, 32'h80112233, 32'h0);
    add  (0, 3'b000, 32'h11,       32'h0,        32'h80112233, 32'h0,        32'h00000022, 3, 1, 0, 32'h80112233, 32'h0);
    add  (1, 3'b001, 32'h22,       32'h1234,     32'hAABBCCDD, 32'h0,        32'h0,        4, 1, 1, 32'h1234CCDD, 32'h0);
    add  (1, 3'b000, 32'h21,       32'hFFFFFFA5, 32'hAABBCCDD, 32'h0,        32'h0,        4, 1, 1, 32'hAABBA5DD, 32'h0);
    add  (1, 3'b010, 32'h24,       32'hCAFEF00D, 32'h55555555, 32'h0,        32'h0,        2, 0, 1, 32'hCAFEF00D, 32'h0);
    add_x(0, 3'b010, 32'h0E,       32'h0,        32'h44332211, 32'h88776655, 32'h66554433, 4, 2, 0, 32'h44332211, 32'h88776655);
    add_x(1, 3'b010, 32'h1F,       32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        6, 2, 2, 32'hEF000000, 32'h00DEADBE);
    add_x(0, 3'b001, 32'h13,       32'h0,        32'h44332211, 32'h887766F5, 32'hFFFFF544, 4, 2, 0, 32'h44332211, 32'h887766F5);
    add_x(0, 3'b001, 32'h11,       32'h0,        32'h44332211, 32'h0,        32'h00003322, 3, 1, 0, 32'h44332211, 32'h0);
    add_x(1, 3'b001, 32'h33,       32'hBEEF,     32'h11111111, 32'h22222222, 32'h0,        6, 2, 2, 32'hEF111111, 32'h222222BE);
    add  (0, 3'b011, 32'h40,       32'h0,        32'h12345678, 32'h0,        32'h12345678, 3, 1, 0, 32'h12345678, 32'h0);
    add  (1, 3'b110, 32'h44,       32'h0BADF00D, 32'h0,        32'h0,        32'h0,        2, 0, 1, 32'h0BADF00D, 32'h0);
    add_x(0, 3'b010, 32'hFFFFFFFE, 32'h0,        32'hAABBCCDD, 32'h11223344, 32'h3344AABB, 4, 2, 0, 32'hAABBCCDD, 32'h11223344);
    add  (1, 3'b000, 32'h13,       32'h12345677, 32'h0,        32'h0,        32'h0,        4, 1, 1, 32'h77000000, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset req_ready", {31'b0, req_ready}, 32'd0);
    chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset resp_misaligned", {31'b0, resp_misaligned}, 32'd0);
    chk("reset strobes", {30'b0, mem_read_en, mem_write_en}, 32'd0);
    chk("reset mem_access_addr", mem_access_addr, 32'h0);
    chk("reset mem_in", mem_in, 32'h0);
    chk("reset mem_data_size", {29'b0, mem_data_size}, 32'd2);
    reset = 1'b0;
    #1 chk("ready after reset", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset during RD_HI (RD_LO when accesses are not split): no response, no write.
    poke(32'h0C, 32'h44332211);
    poke(32'h10, 32'h88776655);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 3'b010;
    req_addr = Split ? 32'h0E : 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (Split) @(negedge clk);
    chk("mid-op read strobe", {31'b0, mem_read_en}, 32'd1);
    chk("mid-op read addr", mem_access_addr, 32'h10);
    reset = 1'b1;
    #1 chk("reset forces read_en low", {31'b0, mem_read_en}, 32'd0);
    chk("reset forces ready low", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready after mid-op reset", {31'b0, req_ready}, 32'd1);
    quiet_cycles("no response after reset (load)", 5);

    // Store reset just before its second write: word A updated, word B untouched.
    poke(32'h1C, 32'h0);
    poke(32'h20, 32'h0);
    poke(32'h24, 32'hAABBCCDD);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1;
    req_size  = Split ? 3'b010 : 3'b001;
    req_addr  = Split ? 32'h1F : 32'h26;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (Split ? 4 : 2) @(negedge clk);
    chk("pending write strobe", {31'b0, mem_write_en}, 32'd1);
    chk("pending write addr", mem_access_addr, Split ? 32'h20 : 32'h24);
    reset = 1'b1;
    #1 chk("reset forces write_en low", {31'b0, mem_write_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet_cycles("no response after reset (store)", 5);
    chk("word A after store reset", Split ? mem[8'h07] : mem[8'h09],
        Split ? 32'hEF000000 : 32'hAABBCCDD);
    chk("word B after store reset", mem[8'h08], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the data memory port. Accepts one load or store per handshake from the execute/memory stage, issues only word-aligned 32-bit accesses to the data memory, and performs byte-lane extraction, sign/zero extension and read-modify-write merging itself. It splits word-crossing accesses into two word accesses and returns one response pulse per request.

## Interface
- No parameters. Memory read latency is fixed at 1 cycle: data is registered on the edge that samples the address.
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE while reset is low
- req_write  in  1  1 = store, 0 = load
- req_size  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; other codes are treated as word
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_misaligned  out  1  request faulted; valid with resp_valid
- mem_access_addr  out  32  word-aligned address, bits[1:0] always 00
- mem_in  out  32  write data
- mem_write_en  out  1  write strobe
- mem_read_en  out  1  read strobe
- mem_data_size  out  3  constant 3'b010
- mem_out  in  32  read data, valid in the cycle after the read strobe

## Operation
- Handshake: acceptance occurs on the edge where req_valid & req_ready. req_write, req_size, req_addr and req_wdata are latched at acceptance. Exactly one request is outstanding at a time.
- Word addresses: A = addr & ~3; B = A + 4, computed modulo 2^32.
- A request crosses a word when it is a halfword at offset 3, or a word at offset 1, 2 or 3.
- States: IDLE, RD_LO, RD_HI, MERGE, WR_LO, WR_HI, RESP.
- IDLE on acceptance:
  - faulting request -> RESP
  - aligned word store -> WR_LO
  - anything else -> RD_LO
- RD_LO: read A. Next state is RD_HI if the request crosses, otherwise MERGE.
- RD_HI: read B; capture mem_out into lo_buf. Next MERGE.
- MERGE: capture mem_out into hi_buf if the request crosses, otherwise into lo_buf. Load -> RESP; store -> WR_LO.
- WR_LO: write the merged lo word to A. Next state is WR_HI if the request crosses, otherwise RESP.
- WR_HI: write the merged hi word to B. Next RESP.
- RESP: resp_valid = 1. Next IDLE.
- Load extraction: bytes = {hi_buf, lo_buf} >> (8 × addr[1:0]). Sign-extend bit 7 for 000 and bit 15 for 001; zero-extend for 100 and 101; sizes 010, 011, 110 and 111 take the full 32 bits.
- Store merge: replace the addressed bytes of {hi_buf, lo_buf} with the low 1, 2 or 4 bytes of wdata. The aligned word store bypasses this and writes wdata directly.
- In every non-memory state, mem_read_en = mem_write_en = 0. At most one strobe is asserted per cycle.

## Timing
- Reset values:
  - state = IDLE; req_ready = 0 while reset is high
  - resp_valid = 0, resp_rdata = 0, resp_misaligned = 0
  - mem_read_en = 0, mem_write_en = 0, mem_access_addr = 0, mem_in = 0
  - mem_data_size = 3'b010
- Memory-side outputs are combinational from state and latched registers, and are forced to their reset values while reset is high.
- resp_valid appears N cycles after the acceptance edge:
  - aligned word store: 2
  - non-crossing load: 3
  - crossing load: 4
  - non-crossing sub-word store: 4
  - crossing store: 6
  - fault: 1
- req_ready returns high in the cycle after RESP. Back-to-back requests therefore see one IDLE cycle between them.
- Reset mid-operation: return to IDLE on the next edge with no response. A crossing store reset after WR_LO leaves word A written and word B unchanged.

## Configuration
- LSU_MISALIGNED_EN defined: crossing accesses are split as described above, and resp_misaligned is always 0.
- LSU_MISALIGNED_EN undefined: any access that is not naturally aligned faults. This covers a halfword at an odd address and a word at a non-zero offset. On a fault:
  - no memory strobes are issued
  - resp_valid is asserted 1 cycle after acceptance, with resp_misaligned = 1 and resp_rdata = 0
  - RD_HI and WR_HI are not built

## Test plan
- Aligned load: word 0x10 = 0x8899AABB; lw 0x10 -> resp_rdata 0x8899AABB, 3 cycles after acceptance, mem_read_en high for exactly 1 cycle.
- Byte loads: word 0x10 = 0x80112233. lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080.
- Sub-word store: word 0x20 = 0xAABBCCDD; sh 0x1234 at 0x22 -> one read of 0x20, then a write of 0x1234CCDD at 0x20; resp_valid 4 cycles after acceptance.
- Crossing load: words 0x0C = 0x44332211 and 0x10 = 0x88776655; lw 0x0E.
  - With the macro: reads 0x0C then 0x10; resp_rdata 0x66554433.
  - Without the macro: resp_misaligned = 1, rdata 0, no strobes.
- Crossing store with the macro: words 0x1C and 0x20 = 0; sw 0xDEADBEEF at 0x1F -> 0x1C = 0xEF000000, 0x20 = 0x00DEADBE; resp_valid 6 cycles after acceptance.
- Reset during RD_HI: state is IDLE on the next edge; no response and no write; req_ready = 1 in the first cycle after reset falls.
